// File: rtl/contador_barrido_digitos_if.sv
// Bus between the digit-scan counter, the BCD source and the seven-segment decoder.
// Width of the digit index follows the number of scanned digits.
interface contador_barrido_digitos_if #(
  parameter int NUM_DIGITOS = 6
) ();
  localparam int IW = (NUM_DIGITOS > 2) ? $clog2(NUM_DIGITOS) : 1;

  logic                     habilitar;
  logic [4*NUM_DIGITOS-1:0] datos_bcd;
  logic                     negativo;
  logic [NUM_DIGITOS-1:0]   anodos;
  logic [3:0]               bcd_actual;
  logic                     es_signo;
  logic                     apagado;
  logic [IW-1:0]            contador_actualizar;

  modport master (
    output habilitar, datos_bcd, negativo,
    input  anodos, bcd_actual, es_signo, apagado, contador_actualizar
  );

  modport slave (
    input  habilitar, datos_bcd, negativo,
    output anodos, bcd_actual, es_signo, apagado, contador_actualizar
  );
endinterface

// File: rtl/contador_barrido_digitos.sv
// Multiplexed display scanner: refresh prescaler, one-hot anodes, per-frame BCD
// snapshot with leading-zero blanking and minus-sign placement.
module contador_barrido_digitos #(
  parameter int NUM_DIGITOS       = 6,
  parameter int DIV_REFRESCO      = 100000,
  parameter int ANODO_ACTIVO_BAJO = 1,
  parameter int SUPRIMIR_CEROS    = 1
) (
  input  logic reloj,
  input  logic reset,
  contador_barrido_digitos_if.slave bus
);
  localparam int IW = (NUM_DIGITOS > 2) ? $clog2(NUM_DIGITOS) : 1;
  localparam int PW = $clog2(DIV_REFRESCO);
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_DIGITOS - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_REFRESCO - 1);
  localparam logic [NUM_DIGITOS-1:0] INACTIVO =
    (ANODO_ACTIVO_BAJO != 0) ? {NUM_DIGITOS{1'b1}} : {NUM_DIGITOS{1'b0}};

  logic [PW-1:0]            presc_q, presc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [4*NUM_DIGITOS-1:0] snap_bcd_q, snap_bcd_d;
  logic                     snap_neg_q, snap_neg_d;
  logic                     primero_q, primero_d;
  logic [NUM_DIGITOS-1:0]   anodos_q, anodos_d;
  logic [3:0]               bcd_q, bcd_d;
  logic                     signo_q, signo_d;
  logic                     apagado_q, apagado_d;

  logic                     tick_s;
  logic [IW:0]              msd_s;
  logic [IW:0]              pos_s;
  logic [NUM_DIGITOS-1:0]   activo_s;
  logic [3:0]               nibble_s;

  assign tick_s = bus.habilitar && (presc_q == PRESC_MAX);
  assign pos_s  = {1'b0, idx_q};

  // Most significant nonzero digit of the snapshot, plus the active digit's nibble and anode.
  always_comb begin
    msd_s    = '0;
    nibble_s = 4'h0;
    activo_s = '0;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      msd_s       = (snap_bcd_q[4*i +: 4] != 4'h0) ? (IW+1)'(i) : msd_s;
      activo_s[i] = (idx_q == IW'(i));
      nibble_s    = (idx_q == IW'(i)) ? snap_bcd_q[4*i +: 4] : nibble_s;
    end
  end

  // Prescaler, digit index and frame snapshot; the snapshot only moves at frame boundaries.
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    snap_bcd_d = snap_bcd_q;
    snap_neg_d = snap_neg_q;
    primero_d  = primero_q;
    if (tick_s) begin
      presc_d   = '0;
      idx_d     = (idx_q == ULTIMO) ? '0 : idx_q + IW'(1);
      primero_d = 1'b0;
      if (primero_q || (idx_q == ULTIMO)) begin
        snap_bcd_d = bus.datos_bcd;
        snap_neg_d = bus.negativo;
      end else begin
        snap_bcd_d = snap_bcd_q;
        snap_neg_d = snap_neg_q;
      end
    end else if (bus.habilitar) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Display decode for the digit selected during the previous cycle.
  always_comb begin
    anodos_d  = INACTIVO;
    bcd_d     = 4'h0;
    signo_d   = 1'b0;
    apagado_d = 1'b1;
    if (bus.habilitar) begin
      anodos_d = (ANODO_ACTIVO_BAJO != 0) ? ~activo_s : activo_s;
      if ((SUPRIMIR_CEROS == 0) || (pos_s <= msd_s)) begin
        bcd_d     = nibble_s;
        apagado_d = 1'b0;
      end else if ((pos_s == msd_s + (IW+1)'(1)) && snap_neg_q) begin
        signo_d   = 1'b1;
        apagado_d = 1'b0;
      end else begin
        apagado_d = 1'b1;
      end
    end else begin
      anodos_d = INACTIVO;
    end
  end

  // State and registered display outputs; reset has priority over any tick.
  always_ff @(posedge reloj) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      snap_bcd_q <= '0;
      snap_neg_q <= 1'b0;
      primero_q  <= 1'b1;
      anodos_q   <= INACTIVO;
      bcd_q      <= 4'h0;
      signo_q    <= 1'b0;
      apagado_q  <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_bcd_q <= snap_bcd_d;
      snap_neg_q <= snap_neg_d;
      primero_q  <= primero_d;
      anodos_q   <= anodos_d;
      bcd_q      <= bcd_d;
      signo_q    <= signo_d;
      apagado_q  <= apagado_d;
    end
  end

  assign bus.anodos              = anodos_q;
  assign bus.bcd_actual          = bcd_q;
  assign bus.es_signo            = signo_q;
  assign bus.apagado             = apagado_q;
  assign bus.contador_actualizar = idx_q;
endmodule

// File: doc/contador_barrido_digitos.md
Name: contador_barrido_digitos

Overview:
Parametrised successor to the fixed 0..5 digit-update counter. It generates its own refresh tick from the system clock, scans N display digits, and drives one-hot anodes. It also selects the BCD nibble for the active digit, blanks leading zeros, and places a minus-sign position for negative Booth products. It sits between the binary-to-BCD converter and the seven-segment decoder.

Parameters:
NUM_DIGITOS, 6, digits scanned; legal range 2..8.
DIV_REFRESCO, 100000, system clock cycles per digit slot; must be at least 2.
ANODO_ACTIVO_BAJO, 1, 1 means the active anode is 0 and inactive anodes are 1; 0 inverts this.
SUPRIMIR_CEROS, 1, 1 enables leading-zero blanking and sign placement; 0 shows every digit and never asserts es_signo.

Ports:
reloj  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
habilitar  input  1  scan enable.
datos_bcd  input  4*NUM_DIGITOS  packed BCD digits; digit 0 (least significant) is in [3:0].
negativo  input  1  result sign; 1 means negative.
anodos  output  NUM_DIGITOS  one-hot anode select; polarity set by ANODO_ACTIVO_BAJO.
bcd_actual  output  4  nibble for the active digit.
es_signo  output  1  active digit shows "-"; bcd_actual is 0 while this is set.
apagado  output  1  active digit is blank; bcd_actual is 0 while this is set.
contador_actualizar  output  max(1,$clog2(NUM_DIGITOS))  active digit index.

Behaviour:
- Reset (sampled on the reloj edge) has priority over everything.
  - Prescaler = 0, contador_actualizar = 0.
  - Frame snapshot: BCD part = 0, sign part = 0.
  - anodos all inactive; bcd_actual = 0; es_signo = 0; apagado = 1.
  - Reset asserted mid-scan takes effect at the next edge, with no partial slot completed.
- Prescaler counts 0..DIV_REFRESCO-1 and wraps to 0.
  - tick = (prescaler == DIV_REFRESCO-1) while habilitar = 1.
- On tick, contador_actualizar advances by 1. When it equals NUM_DIGITOS-1 it wraps to 0, never reaching NUM_DIGITOS.
- Frame snapshot:
  - datos_bcd and negativo are captured into internal registers on the tick where the index wraps NUM_DIGITOS-1 -> 0.
  - They are also captured on the first tick after reset.
  - Input changes mid-frame are not visible until the next frame, so no tearing.
- Significant-digit rule, applied to the snapshot:
  - msd = index of the highest nonzero nibble; msd = 0 if all nibbles are zero.
  - Digit i with i > msd is a leading zero.
  - Digit 0 is never blanked.
  - Nibbles > 9 pass through unchanged and count as nonzero.
- Per-digit output with SUPRIMIR_CEROS = 1:
  - i <= msd: digit shown; bcd_actual = nibble; es_signo = 0; apagado = 0.
  - i == msd+1 and sign snapshot = 1: minus sign; es_signo = 1; apagado = 0; bcd_actual = 0.
  - Any other i > msd: blank; apagado = 1; es_signo = 0; bcd_actual = 0.
  - If negative and msd = NUM_DIGITOS-1, the sign is dropped; no overflow flag.
  - Negative zero (all nibbles 0, sign 1) shows "-0" on digits 1 and 0.
- With SUPRIMIR_CEROS = 0, every digit is shown and apagado and es_signo stay 0.
- Output timing:
  - anodos, bcd_actual, es_signo and apagado are registered.
  - They reflect the index and snapshot of the previous cycle, so they change exactly 1 cycle after the index changes.
  - anodos has exactly one active bit whenever habilitar has been 1 for at least 1 cycle.
- habilitar = 0:
  - Prescaler, index and snapshot hold.
  - From the next edge, anodos are all inactive and apagado = 1.
  - When habilitar returns to 1, the scan resumes from the held prescaler and index; no restart.
- Simultaneous reset and tick: reset wins.
- Simultaneous wrap-tick and datos_bcd change: the value present at that edge is captured.

Test Plan:
1. NUM_DIGITOS=6, DIV_REFRESCO=4; reset 3 cycles, release, habilitar=1 -> index steps 0,1,2,3,4,5,0 every 4 cycles; active-low anodos go 111110 -> 111101 -> ... -> 011111 -> 111110, each 1 cycle after the index change.
2. datos_bcd = 0x000123, negativo=0 -> digits 0..2 show 3,2,1 with apagado=0; digits 3..5 have apagado=1.
3. datos_bcd = 0x000045, negativo=1 -> digits 0..1 show 5,4; digit 2 has es_signo=1, bcd_actual=0; digits 3..5 blank. With 0x987654 and negativo=1 -> all 6 digits shown, es_signo never asserted.
4. Change datos_bcd from 0x000111 to 0x000222 while index=2 -> remaining slots of the frame still show 1; the new value appears only from the next index-0 slot.
5. Deassert habilitar while index=3 for 10 cycles -> anodos=111111, apagado=1, index stays 3; reassert -> scan resumes at index 3 with no reset of the index.
6. Assert reset while index=4 and prescaler=2 -> next edge: index=0, prescaler=0, anodos=111111, bcd_actual=0; all zeros with negativo=1 afterwards -> "-0" on digits 1 and 0. Repeat with SUPRIMIR_CEROS=0 -> all 6 digits show 0.
